// File: rtl/ov7670_camera_read_pkg.sv
// Shared definitions for the OV7670 parallel-bus capture path:
// bus widths and the capture FSM state encoding.
package ov7670_camera_read_pkg;

  localparam int CAM_BYTE_W  = 8;
  localparam int CAM_PIXEL_W = 16;

  typedef enum logic {
    WAIT_FRAME_START = 1'b0,
    ROW_CAPTURE      = 1'b1
  } cam_state_t;

endpackage

// File: rtl/ov7670_camera_read.sv
// OV7670 byte-to-pixel deserializer: waits for a VSYNC falling edge, then pairs
// HREF-qualified bytes (high byte first) into 16-bit pixels until VSYNC rises again.
module ov7670_camera_read
  import ov7670_camera_read_pkg::*;
(
  input  logic                   p_clock,
  input  logic                   rst,
  input  logic                   vsync,
  input  logic                   href,
  input  logic [CAM_BYTE_W-1:0]  p_data,
  output logic [CAM_PIXEL_W-1:0] pixel_data,
  output logic                   pixel_valid,
  output logic                   frame_done
);

  cam_state_t state;
  logic       phase;
  logic       vsync_d;

  always_ff @(posedge p_clock or negedge rst) begin
    if (!rst) begin
      vsync_d <= 1'b0;
    end else begin
      vsync_d <= vsync;
    end
  end

  // A frame only starts on a full VSYNC high-to-low transition, so leaving reset
  // with VSYNC already low never captures a partial first frame.
  always_ff @(posedge p_clock or negedge rst) begin
    if (!rst) begin
      state       <= WAIT_FRAME_START;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      phase       <= 1'b0;
    end else begin
      case (state)
        WAIT_FRAME_START: begin
          pixel_valid <= 1'b0;
          frame_done  <= 1'b0;
          phase       <= 1'b0;
          if (vsync_d && !vsync) begin
            state <= ROW_CAPTURE;
          end
        end
        ROW_CAPTURE: begin
          if (vsync) begin
            frame_done  <= 1'b1;
            pixel_valid <= 1'b0;
            phase       <= 1'b0;
            state       <= WAIT_FRAME_START;
          end else if (href) begin
            frame_done <= 1'b0;
            if (!phase) begin
              pixel_data[15:8] <= p_data;
              phase            <= 1'b1;
              pixel_valid      <= 1'b0;
            end else begin
              pixel_data[7:0]  <= p_data;
              phase            <= 1'b0;
              pixel_valid      <= 1'b1;
            end
          end else begin
            // Line gap: drop any odd trailing byte so the next line starts on a high byte.
            frame_done  <= 1'b0;
            pixel_valid <= 1'b0;
            phase       <= 1'b0;
          end
        end
        default: begin
          state       <= WAIT_FRAME_START;
          pixel_valid <= 1'b0;
          frame_done  <= 1'b0;
          phase       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_camera_read.sv
// Randomized scoreboard bench for ov7670_camera_read: a line-buffer reference model
// predicts pixels and frame-end pulses with their cycle; a negedge monitor checks them.
module tb_ov7670_camera_read;

  logic        p_clock;
  logic        rst;
  logic        vsync;
  logic        href;
  logic [7:0]  p_data;
  logic [15:0] pixel_data;
  logic        pixel_valid;
  logic        frame_done;

  ov7670_camera_read dut (
    .p_clock     (p_clock),
    .rst         (rst),
    .vsync       (vsync),
    .href        (href),
    .p_data      (p_data),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .frame_done  (frame_done)
  );

  initial p_clock = 1'b0;
  always #5 p_clock = ~p_clock;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } pix_t;

  pix_t       exp_pix[$];
  int         exp_fd[$];
  logic [7:0] m_line[$];
  int         cycle = 0;
  int         checks = 0;
  int         failures = 0;
  int         pix_expected = 0;
  int         pix_seen = 0;
  bit         m_in_frame = 0;
  bit         m_prev_vs = 0;
  bit         last_valid = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference model: a frame is open between a VSYNC fall and the next VSYNC high;
  // bytes of a line collect in a buffer and every completed pair becomes one pixel.
  always @(posedge p_clock or negedge rst) begin
    if (!rst) begin
      m_in_frame = 0;
      m_prev_vs  = 0;
      m_line.delete();
    end else begin
      cycle++;
      if (!m_in_frame) begin
        m_line.delete();
        if (m_prev_vs && !vsync) m_in_frame = 1;
      end else if (vsync) begin
        exp_fd.push_back(cycle);
        m_in_frame = 0;
        m_line.delete();
      end else if (href) begin
        m_line.push_back(p_data);
        if (m_line.size() == 2) begin
          exp_pix.push_back('{cycle, {m_line[0], m_line[1]}});
          pix_expected++;
          m_line.delete();
        end
      end else begin
        m_line.delete();
      end
      m_prev_vs = vsync;
    end
  end

  // Monitor: sample registered outputs half a cycle after the active edge.
  always @(negedge p_clock) begin
    if (rst) begin
      if (pixel_valid) begin
        pix_seen++;
        checkOutput("valid_back_to_back", int'(last_valid), 0);
        if (exp_pix.size() == 0) begin
          checkOutput("spurious_pixel_valid", 1, 0);
        end else begin
          pix_t e;
          e = exp_pix.pop_front();
          checkOutput("pixel_cycle", cycle, e.cyc);
          checkOutput("pixel_data", int'(pixel_data), int'(e.data));
        end
      end
      if (frame_done) begin
        if (exp_fd.size() == 0) begin
          checkOutput("spurious_frame_done", 1, 0);
        end else begin
          checkOutput("frame_done_cycle", cycle, exp_fd.pop_front());
        end
      end
      last_valid = pixel_valid;
    end else begin
      last_valid = 0;
    end
  end

  task automatic applyStimulus(input bit v, input bit h, input logic [7:0] d);
    vsync  = v;
    href   = h;
    p_data = d;
    @(posedge p_clock);
    #2;
  endtask

  task automatic vsyncPulse(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 8'h00);
    applyStimulus(0, 0, 8'h00);
  endtask

  task automatic assertReset();
    rst = 1'b0;
    #1;
    checkOutput("reset_pixel_data", int'(pixel_data), 0);
    checkOutput("reset_pixel_valid", int'(pixel_valid), 0);
    checkOutput("reset_frame_done", int'(frame_done), 0);
    @(posedge p_clock);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst    = 1'b1;
    vsync  = 1'b0;
    href   = 1'b0;
    p_data = 8'h00;
    @(posedge p_clock);
    #2;
    assertReset();
    applyStimulus(0, 0, 8'h00);

    $display("[TB] bytes with no prior VSYNC pulse");
    applyStimulus(0, 1, 8'h12);
    applyStimulus(0, 1, 8'h34);
    applyStimulus(0, 0, 8'h00);
    checkOutput("no_capture_before_vsync", pix_seen, 0);

    $display("[TB] first frame, two pixels");
    vsyncPulse(3);
    applyStimulus(0, 1, 8'hAB);
    applyStimulus(0, 1, 8'hCD);
    applyStimulus(0, 1, 8'h12);
    applyStimulus(0, 1, 8'h34);
    applyStimulus(0, 0, 8'h00);

    $display("[TB] odd trailing byte dropped");
    applyStimulus(0, 1, 8'h11);
    applyStimulus(0, 1, 8'h22);
    applyStimulus(0, 1, 8'h33);
    applyStimulus(0, 0, 8'h00);
    applyStimulus(0, 1, 8'h44);
    applyStimulus(0, 1, 8'h55);
    applyStimulus(0, 0, 8'h00);

    $display("[TB] end of frame, later bytes ignored");
    applyStimulus(1, 0, 8'h00);
    applyStimulus(1, 1, 8'h66);
    applyStimulus(1, 1, 8'h77);
    applyStimulus(0, 0, 8'h00);
    checkOutput("pixels_after_first_frame", pix_seen, 4);

    $display("[TB] reset mid-line");
    vsyncPulse(2);
    applyStimulus(0, 1, 8'h99);
    assertReset();
    applyStimulus(0, 1, 8'h01);
    applyStimulus(0, 1, 8'h02);
    applyStimulus(0, 0, 8'h00);
    vsyncPulse(1);
    applyStimulus(0, 1, 8'h01);
    applyStimulus(0, 1, 8'h02);
    applyStimulus(0, 0, 8'h00);

    $display("[TB] vsync and href rise together");
    applyStimulus(0, 1, 8'h5A);
    applyStimulus(1, 1, 8'hA5);
    applyStimulus(0, 0, 8'h00);

    $display("[TB] randomized frames");
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < int'($urandom_range(1, 4)); i++)
        applyStimulus(1, 1'($urandom_range(0, 1)), 8'($urandom));
      applyStimulus(0, 0, 8'h00);
      for (int l = 0; l < int'($urandom_range(1, 4)); l++) begin
        for (int b = 0; b < int'($urandom_range(0, 7)); b++)
          applyStimulus(($urandom_range(0, 15) == 0), 1, 8'($urandom));
        for (int g = 0; g < int'($urandom_range(1, 3)); g++)
          applyStimulus(0, 0, 8'($urandom));
      end
      applyStimulus(1, 0, 8'h00);
    end

    applyStimulus(0, 0, 8'h00);
    applyStimulus(0, 0, 8'h00);
    applyStimulus(0, 0, 8'h00);
    checkOutput("pending_pixels", exp_pix.size(), 0);
    checkOutput("pending_frame_done", exp_fd.size(), 0);
    checkOutput("pixel_count", pix_seen, pix_expected);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
